// File: rtl/sample_window_gather.sv
// Packs a serial stream of signed samples into an 8-slot window.
// The closed window is held for the averager's pipeline depth, then avg_valid pulses.
module sample_window_gather #(
  parameter int unsigned DATAWIDTH   = 16,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [DATAWIDTH-1:0] a,
  output logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] c,
  output logic [DATAWIDTH-1:0] d,
  output logic [DATAWIDTH-1:0] e,
  output logic [DATAWIDTH-1:0] f,
  output logic [DATAWIDTH-1:0] g,
  output logic [DATAWIDTH-1:0] h,
  output logic [DATAWIDTH-1:0] num,
  output logic                 win_busy,
  output logic                 avg_valid
);

  localparam int unsigned HcntW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [HcntW-1:0]     hcnt_q, hcnt_d;
  logic [DATAWIDTH-1:0] slot_q [8];
  logic [DATAWIDTH-1:0] slot_d [8];
  logic [3:0]           num_q, num_d;
  logic                 avg_valid_q, avg_valid_d;
  logic                 accept;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hcnt_d      = hcnt_q;
    slot_d      = slot_q;
    num_d       = num_q;
    avg_valid_d = 1'b0;
    in_ready    = rst && (state_q == StFill);
    accept      = in_valid && in_ready;

    unique case (state_q)
      StFill: begin
        if (accept) begin
          slot_d[idx_q] = in_data;
          idx_d         = idx_q + 3'd1;
        end
        // A flush with an empty window is dropped: no zero-count window is issued.
        if (accept && ((idx_q == 3'd7) || flush)) begin
          num_d   = {1'b0, idx_q} + 4'd1;
          hcnt_d  = '0;
          state_d = StHold;
        end else if (!accept && flush && (idx_q != 3'd0)) begin
          num_d   = {1'b0, idx_q};
          hcnt_d  = '0;
          state_d = StHold;
        end
      end
      StHold: begin
        if (hcnt_q == HcntW'(HOLD_CYCLES - 1)) begin
          avg_valid_d = 1'b1;
          slot_d      = '{default: '0};
          num_d       = 4'd0;
          idx_d       = 3'd0;
          hcnt_d      = '0;
          state_d     = StFill;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StFill;
      idx_q       <= 3'd0;
      hcnt_q      <= '0;
      slot_q      <= '{default: '0};
      num_q       <= 4'd0;
      avg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hcnt_q      <= hcnt_d;
      slot_q      <= slot_d;
      num_q       <= num_d;
      avg_valid_q <= avg_valid_d;
    end
  end

  assign a         = slot_q[0];
  assign b         = slot_q[1];
  assign c         = slot_q[2];
  assign d         = slot_q[3];
  assign e         = slot_q[4];
  assign f         = slot_q[5];
  assign g         = slot_q[6];
  assign h         = slot_q[7];
  assign num       = {{(DATAWIDTH - 4){1'b0}}, num_q};
  assign win_busy  = (state_q == StHold);
  assign avg_valid = avg_valid_q;

endmodule

// File: tb/tb_sample_window_gather.sv
// Bench for sample_window_gather: a window-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sample_window_gather;

  localparam int unsigned W    = 16;
  localparam int unsigned HOLD = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [W-1:0] a, b, c, d, e, f, g, h, num;
  logic         win_busy;
  logic         avg_valid;
  logic [W-1:0] dut_win [8];

  int n_cmp  = 0;
  int n_fail = 0;

  sample_window_gather #(
    .DATAWIDTH  (W),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .flush    (flush),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .e        (e),
    .f        (f),
    .g        (g),
    .h        (h),
    .num      (num),
    .win_busy (win_busy),
    .avg_valid(avg_valid)
  );

  always #5 clk = ~clk;

  assign dut_win[0] = a;
  assign dut_win[1] = b;
  assign dut_win[2] = c;
  assign dut_win[3] = d;
  assign dut_win[4] = e;
  assign dut_win[5] = f;
  assign dut_win[6] = g;
  assign dut_win[7] = h;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a window is a list of samples; once closed it lives for HOLD edges.
  logic         m_known = 1'b0;
  logic         m_filling;
  logic [W-1:0] m_win [8];
  int           m_count;
  int           m_num;
  int           m_left;
  logic         m_pulse;

  initial begin
    logic         s_rst, s_valid, s_flush;
    logic [W-1:0] s_data;
    forever begin
      @(posedge clk);
      s_rst   = rst;
      s_valid = in_valid;
      s_flush = flush;
      s_data  = in_data;
      if (s_rst !== 1'b1) begin
        m_known   = 1'b1;
        m_filling = 1'b1;
        for (int i = 0; i < 8; i++) m_win[i] = '0;
        m_count = 0;
        m_num   = 0;
        m_left  = 0;
        m_pulse = 1'b0;
      end else if (m_known) begin
        m_pulse = 1'b0;
        if (m_filling) begin
          if (s_valid === 1'b1) begin
            m_win[m_count] = s_data;
            m_count++;
          end
          if (m_count == 8 || (s_flush === 1'b1 && m_count > 0)) begin
            m_num     = m_count;
            m_left    = HOLD;
            m_filling = 1'b0;
          end
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_pulse = 1'b1;
            for (int i = 0; i < 8; i++) m_win[i] = '0;
            m_count   = 0;
            m_num     = 0;
            m_filling = 1'b1;
          end
        end
      end
      @(negedge clk);
      if (m_known) begin
        for (int i = 0; i < 8; i++) chk($sformatf("model slot%0d", i), dut_win[i], m_win[i]);
        chk("model num", num, m_num);
        chk("model win_busy", win_busy, !m_filling);
        chk("model avg_valid", avg_valid, m_pulse);
        chk("model in_ready", in_ready, (rst === 1'b1) && m_filling);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] dat, input logic fl);
    in_valid = 1'b1;
    in_data  = dat;
    flush    = fl;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // Called right after the closing edge; expects the pulse exactly HOLD edges later.
  task automatic wait_pulse(input string name);
    int n;
    n = 0;
    while (avg_valid !== 1'b1 && n < int'(HOLD) + 4) begin
      step();
      n++;
    end
    chk({name, " pulse latency"}, n, HOLD);
    chk({name, " a cleared"}, a, 0);
    chk({name, " num cleared"}, num, 0);
    chk({name, " ready in pulse"}, in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    int lowc;
    int seen;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    flush    = 1'b0;
    step();
    step();
    chk("reset a", a, 0);
    chk("reset num", num, 0);
    chk("reset busy", win_busy, 0);
    chk("reset avg_valid", avg_valid, 0);
    chk("ready low in reset", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("ready after reset", in_ready, 1);

    // Full window 1..8
    for (int i = 1; i <= 8; i++) push(W'(i), 1'b0);
    chk("full a", a, 1);
    chk("full d", d, 4);
    chk("full h", h, 8);
    chk("full num", num, 8);
    chk("full busy", win_busy, 1);
    chk("full ready", in_ready, 0);
    wait_pulse("full");
    step();
    chk("full pulse one cycle", avg_valid, 0);

    // Partial window closed by a lone flush
    push(16'hFFFB, 1'b0);
    push(16'd10, 1'b0);
    push(16'd7, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("partial a", a, 32'h0000FFFB);
    chk("partial b", b, 10);
    chk("partial c", c, 7);
    chk("partial d", d, 0);
    chk("partial h", h, 0);
    chk("partial num", num, 3);
    wait_pulse("partial");
    step();

    // Flush on empty window is ignored; then flush together with 5th accept
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("empty flush num", num, 0);
    chk("empty flush busy", win_busy, 0);
    for (int i = 11; i <= 14; i++) push(W'(i), 1'b0);
    push(16'd100, 1'b1);
    chk("flushacc a", a, 11);
    chk("flushacc e", e, 100);
    chk("flushacc f", f, 0);
    chk("flushacc num", num, 5);
    wait_pulse("flushacc");
    step();

    // Sign extremes, then backpressure with in_valid held through the hold
    push(16'h7FFF, 1'b0);
    push(16'h8000, 1'b0);
    push(16'hFFFF, 1'b0);
    for (int i = 2; i <= 6; i++) push(W'(i), 1'b0);
    chk("extreme a", a, 32'h7FFF);
    chk("extreme b", b, 32'h8000);
    chk("extreme c", c, 32'hFFFF);
    chk("extreme h", h, 6);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    n        = 0;
    lowc     = 0;
    while (avg_valid !== 1'b1 && n < int'(HOLD) + 4) begin
      if (in_ready === 1'b0) lowc++;
      step();
      n++;
    end
    chk("bp pulse latency", n, HOLD);
    chk("bp ready low cycles", lowc, HOLD);
    chk("bp ready in pulse", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp a accepted", a, 32'h1234);
    chk("bp busy", win_busy, 0);
    step();
    chk("bp b no duplicate", b, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("bp num", num, 1);
    wait_pulse("bp");
    step();

    // Reset in the middle of a hold
    for (int i = 1; i <= 8; i++) push(W'(i * 3), 1'b0);
    step();
    step();
    step();
    rst = 1'b0;
    step();
    chk("midrst a", a, 0);
    chk("midrst h", h, 0);
    chk("midrst num", num, 0);
    chk("midrst busy", win_busy, 0);
    chk("midrst ready", in_ready, 0);
    rst  = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (avg_valid === 1'b1) seen++;
      step();
    end
    chk("midrst no pulse", seen, 0);
    for (int i = 1; i <= 8; i++) push(W'(i), 1'b0);
    chk("post rst a", a, 1);
    chk("post rst h", h, 8);
    chk("post rst num", num, 8);
    wait_pulse("post rst");
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_window_gather.md
# sample_window_gather

Upstream feeder for the 8-input pipelined averaging circuit. Accepts a serial stream of signed 16-bit samples over a valid/ready handshake and packs up to eight of them into a parallel window (`a`..`h`) plus a sample count (`num`). It holds the window stable for the averager's full pipeline depth, then flags the cycle in which the averager's `avg` output corresponds to that window. Unused slots in a partial (flushed) window read as zero.

## Interface
- `DATAWIDTH`, 16: sample width, signed two's complement.
- `HOLD_CYCLES`, 8: number of clock edges the window is held after it closes; equals the averager's register depth.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, synchronous, active-low (0 = reset, sampled on `clk` rising edge).
- `in_data` in DATAWIDTH: incoming sample, signed.
- `in_valid` in 1: `in_data` valid this cycle.
- `in_ready` out 1: block accepts a sample this cycle.
- `flush` in 1: close a partial window now.
- `a`,`b`,`c`,`d`,`e`,`f`,`g`,`h` out DATAWIDTH: window slots 0..7, registered, signed.
- `num` out DATAWIDTH: sample count of current window (1..8), registered.
- `win_busy` out 1: window closed and being held (HOLD state).
- `avg_valid` out 1: one-cycle pulse; downstream `avg` reflects this window.

## Operation
- Two states: FILL, HOLD. Slot index `idx` (0..7), hold counter `hcnt` (0..HOLD_CYCLES).
- Reset (`rst`=0 at an edge): state FILL, `idx`=0, `hcnt`=0, `a`..`h`=0, `num`=0, `win_busy`=0, `avg_valid`=0, `in_ready`=0 while `rst` is low.
- FILL: `in_ready`=1. Accept = `in_valid` & `in_ready`. On accept, `in_data` is written to slot `idx`, `idx`+1.
  - Accept with `idx`=7: window closes, `num`=8, go HOLD.
  - `flush`=1 with no accept and `idx`>0: window closes, `num`=`idx`, go HOLD.
  - `flush`=1 together with accept: sample written first, window closes, `num`=`idx`+1.
  - `flush`=1 with `idx`=0 and no accept: ignored (no zero-count window is ever issued).
- HOLD: `in_ready`=0, `win_busy`=1; `a`..`h` and `num` frozen; `flush` and `in_valid` ignored; `hcnt` increments each edge.
  - At the edge where `hcnt` reaches HOLD_CYCLES: `avg_valid`←1 for one cycle, `a`..`h`←0, `num`←0, `idx`←0, `hcnt`←0, go FILL.
- Slots `a`..`h` only change on accept (single slot) or on HOLD exit (all cleared); slots not written in a partial window stay 0.
- No arithmetic on samples; `num` is zero-extended count.

## Timing
- E0 = edge at which the window closes. `a`..`h`/`num` final values visible after E0, stable through E_HOLD_CYCLES (E8 default).
- `win_busy` high from after E0 to after E8; `in_ready` low over the same interval.
- `avg_valid` high exactly one cycle, after E8 (HOLD_CYCLES edges after close); in that same cycle `in_ready`=1 and a new sample may be accepted.
- Full window throughput: 8 accept cycles + 8 hold cycles = 16 cycles minimum per window.
- Reset mid-HOLD or mid-FILL: all state and outputs return to reset values at that edge; no `avg_valid` pulse for the aborted window.
- `in_valid` held high while `in_ready`=0: no sample lost or duplicated; sample accepted on first cycle `in_ready`=1.

## Test plan
- Full window: stream 1,2,…,8 back-to-back -> after 8th accept `a`..`h`=1..8, `num`=8, `win_busy`=1; `avg_valid` pulses 8 edges later; outputs then 0.
- Partial flush: samples -5, 10, 7, then `flush` alone -> `a`=-5,`b`=10,`c`=7,`d`..`h`=0, `num`=3; `avg_valid` 8 edges later.
- Flush with accept: 5th sample 100 with `flush`=1 same cycle -> `e`=100, `num`=5; `flush` with `idx`=0 -> no state change, `num` stays 0.
- Backpressure: hold `in_valid`=1 with new data during HOLD -> `in_ready`=0 for 8 cycles, data accepted into `a` in the `avg_valid` cycle, nothing dropped.
- Reset mid-HOLD: assert `rst`=0 at hold cycle 4 -> next edge all outputs 0, state FILL, no `avg_valid` pulse; next window behaves as full-window case.
- Sign extremes: samples 0x7FFF and 0x8000 pass through unchanged into slots.
